// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared types, channel count and one-hot helper for demux_sched
package demux_sched_pkg;
    localparam int NCH = 4;
    typedef enum logic {MODE_RR, MODE_FIX} mode_e;
    typedef enum logic {ST_EMPTY, ST_FULL} state_e;
    function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
        return NCH'(1) << idx;
    endfunction
endpackage

// File: rtl/demux_sched_if.sv
// demux_sched_if: source stream, four sink handshakes and demux select
interface demux_sched_if #(parameter int DW = 8);
    import demux_sched_pkg::*;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [DW-1:0]  out_data;
    logic [1:0]     sel;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, sel);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, sel);
endinterface

// File: rtl/demux_sched_rr_pick.sv
// rr_pick: first set mask bit at or after ptr, wrapping 3 -> 0
module rr_pick (
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic [1:0] idx,
    output logic       found
);
    always_comb begin
        idx = ptr;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[ptr + 2'(i)]) begin
                idx = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_sched.sv
// demux_sched: one-entry holding stage dispatching to four sinks by round-robin or fixed channel
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [1:0]       fix_sel,
    input  logic [NCH-1:0]   en,
    input  logic             clr,
    input  logic [1:0]       cnt_idx,
    output logic [CNT_W-1:0] cnt_out,
    demux_sched_if.slave     bus
);
    state_e           state_q, state_d;
    logic [DW-1:0]    data_q;
    logic [1:0]       tgt_q, rr_ptr, start, rr_idx, tgt_d;
    logic             rr_found, has_tgt, xfer, cap, fix;
    logic [CNT_W-1:0] cnt [NCH];

    assign fix = mode_e'(mode) == MODE_FIX;
    assign xfer = state_q == ST_FULL && bus.out_ready[tgt_q];
    // a same-cycle recapture searches from the pointer value the transfer is about to write
    assign start = xfer ? tgt_q + 2'd1 : rr_ptr;

    rr_pick u_pick (.ptr(start), .mask(en), .idx(rr_idx), .found(rr_found));

    assign has_tgt = fix || rr_found;
    assign tgt_d = fix ? fix_sel : rr_idx;
    assign bus.in_ready = has_tgt && (state_q == ST_EMPTY || xfer);
    assign cap = bus.in_valid && bus.in_ready;
    assign bus.out_data = data_q;
    assign bus.sel = tgt_q;
    assign cnt_out = cnt[cnt_idx];

    always_comb begin
        state_d = cap ? ST_FULL : xfer ? ST_EMPTY : state_q;
        bus.out_valid = state_q == ST_FULL ? onehot4(tgt_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q <= '0;
            tgt_q <= '0;
            rr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                data_q <= bus.in_data;
                tgt_q <= tgt_d;
            end
            if (xfer && !fix) rr_ptr <= tgt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (xfer) begin
            cnt[tgt_q] <= cnt[tgt_q] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed vectors with hand-computed expectations for demux_sched
module tb_demux_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [1:0] fix_sel = 2'd0;
    logic [3:0] en = 4'b1111;
    logic       clr = 1'b0;
    logic [1:0] cnt_idx = 2'd0;
    logic [7:0] cnt_out;
    int         pass = 0;
    int         total = 0;

    demux_sched_if #(.DW(8)) bus();

    demux_sched #(.DW(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .fix_sel(fix_sel), .en(en),
        .clr(clr), .cnt_idx(cnt_idx), .cnt_out(cnt_out), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        cnt_idx = idx;
        #1;
        check(tag, 32'(cnt_out), 32'(exp));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 4'b0000;
        #1;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_ready", 32'(bus.in_ready), 1);
        check_cnt("rst_cnt", 2'd0, 8'd0);
        step();
        rst = 1'b0;

        // round-robin over all channels, back-to-back
        bus.out_ready = 4'b1111;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            #1;
            check("rr4_ready", 32'(bus.in_ready), 1);
            step();
            check("rr4_valid", 32'(bus.out_valid), 32'(4'b0001 << (i % 4)));
            check("rr4_data", 32'(bus.out_data), 32'h10 + 32'(i));
        end
        bus.in_valid = 1'b0;
        step();
        check("rr4_drain", 32'(bus.out_valid), 0);
        for (int k = 0; k < 4; k++) check_cnt("rr4_cnt", 2'(k), 8'd2);

        // sparse mask 1010 -> channels 1,3,1,3
        en = 4'b1010;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'h20 + 8'(i);
            step();
            check("rr2_valid", 32'(bus.out_valid), (i % 2 == 0) ? 32'b0010 : 32'b1000);
            check("rr2_sel", 32'(bus.sel), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        bus.in_valid = 1'b0;
        step();
        check_cnt("rr2_cnt1", 2'd1, 8'd4);
        check_cnt("rr2_cnt3", 2'd3, 8'd4);
        check_cnt("rr2_cnt0", 2'd0, 8'd2);

        // empty mask blocks capture
        en = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hEE;
        #1;
        check("en0_ready", 32'(bus.in_ready), 0);
        step();
        step();
        check("en0_valid", 32'(bus.out_valid), 0);

        // fixed channel 2 held under backpressure; other sinks' readiness ignored
        mode = 1'b1;
        fix_sel = 2'd2;
        bus.out_ready = 4'b1011;
        bus.in_data = 8'hA5;
        #1;
        check("fix_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fix_hold_valid", 32'(bus.out_valid), 32'b0100);
            check("fix_hold_data", 32'(bus.out_data), 32'hA5);
            check("fix_hold_ready", 32'(bus.in_ready), 0);
            step();
        end
        check("fix_sel", 32'(bus.sel), 2);
        bus.out_ready = 4'b0100;
        #1;
        check("fix_rel_ready", 32'(bus.in_ready), 1);
        step();
        check("fix_done", 32'(bus.out_valid), 0);
        check_cnt("fix_cnt2", 2'd2, 8'd3);

        // backpressure then same-cycle recapture
        mode = 1'b0;
        en = 4'b1111;
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h22;
        step();
        bus.in_data = 8'h33;
        #1;
        check("bp_ready", 32'(bus.in_ready), 0);
        step();
        check("bp_hold_valid", 32'(bus.out_valid), 32'b0001);
        check("bp_hold_data", 32'(bus.out_data), 32'h22);
        bus.out_ready = 4'b0001;
        #1;
        check("bp_recap_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b0000;
        check("bp_next_valid", 32'(bus.out_valid), 32'b0010);
        check("bp_next_data", 32'(bus.out_data), 32'h33);

        // control changes while full do not retarget the locked item
        mode = 1'b1;
        fix_sel = 2'd3;
        en = 4'b0001;
        step();
        check("mid_valid", 32'(bus.out_valid), 32'b0010);
        check("mid_sel", 32'(bus.sel), 1);
        bus.out_ready = 4'b0010;
        step();
        check("mid_done", 32'(bus.out_valid), 0);
        check_cnt("mid_cnt1", 2'd1, 8'd5);
        check_cnt("mid_cnt0", 2'd0, 8'd3);

        // clear wins over a coincident increment
        fix_sel = 2'd0;
        bus.out_ready = 4'b0001;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h44;
        step();
        bus.in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_valid", 32'(bus.out_valid), 0);
        for (int k = 0; k < 4; k++) check_cnt("clr_cnt", 2'(k), 8'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55;
        step();
        bus.in_valid = 1'b0;
        step();
        check_cnt("clr_after", 2'd0, 8'd1);

        // counter wraps modulo 256: 257 transfers on channel 3
        fix_sel = 2'd3;
        bus.out_ready = 4'b1000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.in_data = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check_cnt("wrap_cnt3", 2'd3, 8'd1);

        // asynchronous reset while full
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h66;
        step();
        bus.in_valid = 1'b0;
        check("arst_pre", 32'(bus.out_valid), 32'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_sel", 32'(bus.sel), 0);
        check_cnt("arst_cnt3", 2'd3, 8'd0);
        check_cnt("arst_cnt0", 2'd0, 8'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_after", 32'(bus.out_valid), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
